// File: rtl/urv_cfg.sv
// Shared configuration package: UART register map, base address,
// data-bus request/response types and the FSM state type used by both
// UART serial engines.
package urv_cfg;

    localparam logic [31:0] UART_BASE   = 32'h1000_2000;

    localparam logic [3:0]  UART_TXDATA = 4'h0;
    localparam logic [3:0]  UART_RXDATA = 4'h4;
    localparam logic [3:0]  UART_STATUS = 4'h8;
    localparam logic [3:0]  UART_DIV    = 4'hC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        we;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
    } mem_resp_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. A push while full is accepted only when a pop
// happens in the same cycle; a pop while empty is ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    // Pointer update; reset discards all stored entries.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_lite.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs and a level interrupt.
// Build option: UART_RX_EN enables the receive path (synchroniser,
// RX FSM, RX FIFO); without it RX reads as permanently empty.
module uart_lite
    import urv_cfg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RST    = 16'd868
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      mem_req_valid,
    output logic      mem_req_ready,
    input  mem_req_t  mem_req,
    output logic      mem_resp_valid,
    input  logic      mem_resp_ready,
    output mem_resp_t mem_resp,
    output logic      uart_tx,
    input  logic      uart_rx,
    output logic      uart_irq
);

    logic        accept, wr, rd;
    logic [1:0]  reg_sel;
    logic [31:0] rdata_next;
    logic [15:0] div;
    logic        clr_ov, clr_fe;

    logic        tx_push, tx_pop, tx_full, tx_empty, tx_bit_end;
    logic [7:0]  tx_data, tx_shift;
    uart_state_e tx_state;
    logic [15:0] tx_div, tx_cnt;
    logic [2:0]  tx_idx;

    logic        rx_pop, rx_full, rx_empty, overrun, frame_err;
    logic [7:0]  rx_data;

    logic        unused_bits;

    assign mem_req_ready = !mem_resp_valid;
    assign accept        = mem_req_valid && mem_req_ready;
    assign wr            = accept && mem_req.we;
    assign rd            = accept && !mem_req.we;
    assign reg_sel       = mem_req.addr[3:2];

    assign tx_push = wr && (reg_sel == UART_TXDATA[3:2]) && mem_req.wstrb[0];
    assign rx_pop  = rd && (reg_sel == UART_RXDATA[3:2]);
    assign clr_ov  = wr && (reg_sel == UART_STATUS[3:2]) && mem_req.wdata[5];
    assign clr_fe  = wr && (reg_sel == UART_STATUS[3:2]) && mem_req.wdata[6];

    assign unused_bits = ^{mem_req.addr[31:4], mem_req.addr[1:0],
                           mem_req.wdata[31:16], mem_req.wstrb[3:1]};

    // Read-data mux for the register addressed by the current request.
    always_comb begin
        rdata_next = '0;
        case (reg_sel)
            UART_TXDATA[3:2]: rdata_next = {tx_full, 31'b0};
            UART_RXDATA[3:2]: rdata_next = {rx_empty, 23'b0, rx_empty ? 8'h00 : rx_data};
            UART_STATUS[3:2]: rdata_next = {25'b0, frame_err, overrun, (tx_state != IDLE),
                                            rx_full, rx_empty, tx_full, tx_empty};
            default:          rdata_next = {16'b0, div};
        endcase
    end

    // Registered response; a new request is only accepted once it is consumed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_resp_valid <= 1'b0;
            mem_resp       <= '0;
        end else if (accept) begin
            mem_resp_valid <= 1'b1;
            mem_resp.rdata <= mem_req.we ? '0 : rdata_next;
        end else if (mem_resp_ready) begin
            mem_resp_valid <= 1'b0;
        end
    end

    // Baud divisor register; zero is stored as one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div <= DIV_RST;
        end else if (wr && (reg_sel == UART_DIV[3:2])) begin
            div <= (mem_req.wdata[15:0] == 16'd0) ? 16'd1 : mem_req.wdata[15:0];
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (tx_push),
        .wdata (mem_req.wdata[7:0]),
        .pop   (tx_pop),
        .rdata (tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // A pending byte is loaded straight out of STOP so back-to-back
    // frames keep every bit exactly tx_div cycles long.
    assign tx_bit_end = (tx_cnt == tx_div - 16'd1);
    assign tx_pop     = !tx_empty && ((tx_state == IDLE) || ((tx_state == STOP) && tx_bit_end));

    // TX serialiser: start bit, 8 data bits LSB first, stop bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state <= IDLE;
            tx_div   <= DIV_RST;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else if (tx_pop) begin
            tx_state <= START;
            tx_div   <= div;
            tx_cnt   <= '0;
            tx_shift <= tx_data;
            uart_tx  <= 1'b0;
        end else begin
            if (tx_state != IDLE) tx_cnt <= tx_bit_end ? '0 : tx_cnt + 16'd1;
            case (tx_state)
                IDLE:  ;
                START: if (tx_bit_end) begin
                    tx_state <= DATA;
                    tx_idx   <= '0;
                    uart_tx  <= tx_shift[0];
                end
                DATA:  if (tx_bit_end) begin
                    if (tx_idx == 3'd7) begin
                        tx_state <= STOP;
                        uart_tx  <= 1'b1;
                    end else begin
                        tx_idx   <= tx_idx + 3'd1;
                        tx_shift <= tx_shift >> 1;
                        uart_tx  <= tx_shift[1];
                    end
                end
                STOP:  if (tx_bit_end) tx_state <= IDLE;
            endcase
        end
    end

`ifdef UART_RX_EN
    logic        rx_s1, rx_s2, rx_prev;
    uart_state_e rx_state;
    logic [15:0] rx_div, rx_cnt, rx_half;
    logic [2:0]  rx_idx;
    logic [7:0]  rx_shift;
    logic        rx_bit_end, rx_stop_sample, rx_push, ov_set, fe_set;

    // Two-flop synchroniser plus one delay stage for falling-edge detect.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Edge detection already costs one cycle, so the start sample fires one
    // count early to land near the middle of the start bit.
    assign rx_half        = (rx_div[15:1] == 15'd0) ? 16'd0 : {1'b0, rx_div[15:1]} - 16'd1;
    assign rx_bit_end     = (rx_cnt == rx_div - 16'd1);
    assign rx_stop_sample = (rx_state == STOP) && rx_bit_end;
    assign rx_push        = rx_stop_sample && rx_s2;
    assign fe_set         = rx_stop_sample && !rx_s2;
    assign ov_set         = rx_push && rx_full && !rx_pop;

    // RX deserialiser; returns to IDLE at the stop-bit sample.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_state <= IDLE;
            rx_div   <= DIV_RST;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                IDLE: if (rx_prev && !rx_s2) begin
                    rx_state <= START;
                    rx_div   <= div;
                    rx_cnt   <= '0;
                end
                START: if (rx_cnt == rx_half) begin
                    rx_cnt   <= '0;
                    rx_idx   <= '0;
                    rx_state <= rx_s2 ? IDLE : DATA;
                end else begin
                    rx_cnt <= rx_cnt + 16'd1;
                end
                DATA: if (rx_bit_end) begin
                    rx_cnt   <= '0;
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_idx   <= rx_idx + 3'd1;
                    if (rx_idx == 3'd7) rx_state <= STOP;
                end else begin
                    rx_cnt <= rx_cnt + 16'd1;
                end
                STOP: if (rx_bit_end) begin
                    rx_cnt   <= '0;
                    rx_state <= IDLE;
                end else begin
                    rx_cnt <= rx_cnt + 16'd1;
                end
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= ov_set || (overrun && !clr_ov);
            frame_err <= fe_set || (frame_err && !clr_fe);
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (rx_push),
        .wdata (rx_shift),
        .pop   (rx_pop),
        .rdata (rx_data),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign uart_irq = !rx_empty || overrun || frame_err;
`else
    logic unused_rx;

    assign rx_full   = 1'b0;
    assign rx_empty  = 1'b1;
    assign rx_data   = '0;
    assign overrun   = 1'b0;
    assign frame_err = 1'b0;
    assign uart_irq  = 1'b0;
    assign unused_rx = ^{uart_rx, rx_pop, clr_ov, clr_fe};
`endif

endmodule
